btn_event_ctrl: RTL and testbench

BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

---
 rtl/btn_evt_pkg.sv | 21 ++
 rtl/btn_evt_fifo.sv | 50 +++++
 rtl/btn_event_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_btn_event_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared encodings for the button event controller: event types, channel FSM
// states and widths used by the controller and its event queue.
package btn_evt_pkg;

  localparam int EVT_TYPE_W = 2;
  localparam int MS_CNT_W   = 12;

  typedef enum logic [EVT_TYPE_W-1:0] {
    EVT_PRESS   = 2'd0,
    EVT_RELEASE = 2'd1,
    EVT_LONG    = 2'd2,
    EVT_REPEAT  = 2'd3
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_e;

endpackage

// File: rtl/btn_evt_fifo.sv
// Synchronous FIFO with show-ahead read data; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module btn_evt_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rd_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/btn_event_ctrl.sv
// Per-button PRESS/RELEASE/LONG/REPEAT event generator with one pending slot
// per channel, round-robin arbitration and a shared event FIFO.
module btn_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int   NUM_BTNS      = 4,
  parameter int   CLKIN_FREQ    = 27_000_000,
  parameter int   LONG_PRESS_MS = 500,
  parameter int   REPEAT_MS     = 100,
  parameter logic IDLE_STATE    = 1'b1,
  parameter int   FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_BTNS-1:0]         btn_lvl,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [$clog2(NUM_BTNS)-1:0] evt_id,
  output logic [EVT_TYPE_W-1:0]       evt_type,
  output logic                        overflow,
  input  logic                        ovf_clr
);

  localparam int ID_W     = $clog2(NUM_BTNS);
  localparam int ENTRY_W  = ID_W + EVT_TYPE_W;
  localparam int TICK_DIV = CLKIN_FREQ / 1000;
  localparam int PS_W     = $clog2(TICK_DIV + 1);
  localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(TICK_DIV - 1);
  localparam logic [MS_CNT_W-1:0] LONG_LIM = MS_CNT_W'(LONG_PRESS_MS);
  localparam logic [MS_CNT_W-1:0] RPT_LIM  = MS_CNT_W'(REPEAT_MS);

  logic [PS_W-1:0] ps_cnt;
  logic            ms_tick;

  btn_state_e          state     [NUM_BTNS];
  btn_state_e          state_nxt [NUM_BTNS];
  logic [MS_CNT_W-1:0] cnt       [NUM_BTNS];
  logic [MS_CNT_W-1:0] cnt_nxt   [NUM_BTNS];
  logic [NUM_BTNS-1:0] raise;
  evt_type_e           raise_type [NUM_BTNS];

  logic [NUM_BTNS-1:0] pend_valid;
  evt_type_e           pend_type [NUM_BTNS];
  logic [NUM_BTNS-1:0] grant;
  logic [NUM_BTNS-1:0] drop;
  logic [ID_W-1:0]     last;
  logic [ID_W-1:0]     gnt_id;
  logic [ID_W-1:0]     cand;

  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic               can_write;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;

  // Shared millisecond prescaler.
  assign ms_tick = (ps_cnt == PS_LAST);

  always_ff @(posedge clk) begin
    if (reset)        ps_cnt <= '0;
    else if (ms_tick) ps_cnt <= '0;
    else              ps_cnt <= ps_cnt + PS_W'(1);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (reset) begin
        state[i] <= ST_IDLE;
        cnt[i]   <= '0;
      end else begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    for (int i = 0; i < NUM_BTNS; i++) begin
      state_nxt[i]  = state[i];
      cnt_nxt[i]    = cnt[i];
      raise[i]      = 1'b0;
      raise_type[i] = EVT_PRESS;
      case (state[i])
        ST_IDLE: begin
          if (btn_lvl[i] != IDLE_STATE) begin
            state_nxt[i] = ST_PRESSED;
            cnt_nxt[i]   = '0;
            raise[i]     = 1'b1;
          end
        end
        ST_PRESSED, ST_HELD: begin
          // Release is checked first so it overrides a same-cycle LONG/REPEAT.
          if (btn_lvl[i] == IDLE_STATE) begin
            state_nxt[i]  = ST_IDLE;
            raise[i]      = 1'b1;
            raise_type[i] = EVT_RELEASE;
          end else if (ms_tick) begin
            if (state[i] == ST_PRESSED && cnt[i] + 12'd1 == LONG_LIM) begin
              state_nxt[i]  = ST_HELD;
              cnt_nxt[i]    = '0;
              raise[i]      = 1'b1;
              raise_type[i] = EVT_LONG;
            end else if (state[i] == ST_HELD && cnt[i] + 12'd1 == RPT_LIM) begin
              cnt_nxt[i]    = '0;
              raise[i]      = 1'b1;
              raise_type[i] = EVT_REPEAT;
            end else begin
              cnt_nxt[i] = cnt[i] + 12'd1;
            end
          end
        end
        default: state_nxt[i] = ST_IDLE;
      endcase
    end
  end

  // A raised event is lost only if its slot is still occupied after this cycle.
  assign drop = raise & pend_valid & ~grant;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (reset) begin
        pend_valid[i] <= 1'b0;
        pend_type[i]  <= EVT_PRESS;
      end else if (raise[i] && !drop[i]) begin
        pend_valid[i] <= 1'b1;
        pend_type[i]  <= raise_type[i];
      end else if (grant[i]) begin
        pend_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        overflow <= 1'b0;
    else if (|drop)   overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

  assign fifo_pop  = evt_valid && evt_ready;
  assign can_write = !fifo_full || fifo_pop;

  always_comb begin
    grant  = '0;
    gnt_id = '0;
    cand   = '0;
    for (int off = 1; off <= NUM_BTNS; off++) begin
      cand = ID_W'((int'(last) + off) % NUM_BTNS);
      if (can_write && grant == '0 && pend_valid[cand]) begin
        grant[cand] = 1'b1;
        gnt_id      = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       last <= ID_W'(NUM_BTNS - 1);
    else if (|grant) last <= gnt_id;
  end

  assign fifo_wdata = {gnt_id, pend_type[gnt_id]};

  btn_evt_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (|grant),
    .wr_data (fifo_wdata),
    .pop     (fifo_pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid          = !fifo_empty;
  assign {evt_id, evt_type} = evt_valid ? fifo_rdata : '0;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl: 1 ms = 10 clocks, LONG after 5 ms,
// REPEAT every 2 ms; expected events and cycle stamps are hand-derived.
module tb_btn_event_ctrl;

  localparam int P  = 0;
  localparam int R  = 1;
  localparam int L  = 2;
  localparam int RP = 3;

  typedef struct {
    int id;
    int typ;
    int cyc;
  } evt_log_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn_lvl;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic [1:0] evt_type;
  logic       overflow;
  logic       ovf_clr;

  int       cyc = 0;
  int       vectors = 0;
  int       miscompares = 0;
  evt_log_t evt_q[$];

  int rr_a_ids[4]  = '{2, 3, 0, 1};
  int drain_ids[6] = '{0, 1, 2, 0, 1, 2};
  int drain_typ[6] = '{P, P, P, R, R, R};

  btn_event_ctrl #(
    .NUM_BTNS      (4),
    .CLKIN_FREQ    (10_000),
    .LONG_PRESS_MS (5),
    .REPEAT_MS     (2),
    .IDLE_STATE    (1'b1),
    .FIFO_DEPTH    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_lvl   (btn_lvl),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_id    (evt_id),
    .evt_type  (evt_type),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every accepted event with the number of the edge that preceded it.
  always @(negedge clk) begin
    evt_log_t e;
    if (evt_valid && evt_ready) begin
      e.id  = int'(evt_id);
      e.typ = int'(evt_type);
      e.cyc = cyc;
      evt_q.push_back(e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_evt(input int k, input int id, input int typ, input int c);
    if (k < evt_q.size()) begin
      check($sformatf("evt%0d_id", k),   evt_q[k].id,  id);
      check($sformatf("evt%0d_type", k), evt_q[k].typ, typ);
      check($sformatf("evt%0d_cyc", k),  evt_q[k].cyc, c);
    end else begin
      check($sformatf("evt%0d_present", k), evt_q.size(), k + 1);
    end
  endtask

  initial begin
    reset     = 1'b1;
    btn_lvl   = 4'hF;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;

    // Reset state
    step(1);
    check("rst_valid", evt_valid, 0);
    check("rst_id",    evt_id,    0);
    check("rst_type",  evt_type,  0);
    check("rst_ovf",   overflow,  0);
    step(2);
    reset = 1'b0;                          // after edge 3

    // Short press on button 2: PRESS 2 cycles after the fall, RELEASE, no LONG
    btn_lvl[2] = 1'b0;
    step(1);                               // edge 4
    check("short_lat1_valid", evt_valid, 0);
    step(1);                               // edge 5
    check("short_press_valid", evt_valid, 1);
    check("short_press_id",    evt_id,    2);
    check("short_press_type",  evt_type,  P);
    step(1);                               // edge 6
    check("short_popped", evt_valid, 0);
    btn_lvl[2] = 1'b1;
    step(2);                               // edge 8
    check("short_rel_valid", evt_valid, 1);
    check("short_rel_id",    evt_id,    2);
    check("short_rel_type",  evt_type,  R);
    step(1);                               // edge 9
    check("short_no_long", evt_valid, 0);
    evt_q.delete();

    // Long hold on button 1; ms ticks land on edges 13, 23, ...
    btn_lvl[1] = 1'b0;
    step(100);                             // edge 109
    btn_lvl[1] = 1'b1;
    step(3);                               // edge 112
    check("hold_count", evt_q.size(), 5);
    check_evt(0, 1, P,  11);
    check_evt(1, 1, L,  54);
    check_evt(2, 1, RP, 74);
    check_evt(3, 1, RP, 94);
    check_evt(4, 1, R,  111);
    evt_q.delete();

    // All four together with last grant = 1
    btn_lvl = 4'h0;
    step(6);                               // edge 118
    btn_lvl = 4'hF;
    step(6);                               // edge 124
    check("rr_a_count", evt_q.size(), 8);
    for (int k = 0; k < 4; k++) begin
      check_evt(k,     rr_a_ids[k], P, 114 + k);
      check_evt(k + 4, rr_a_ids[k], R, 120 + k);
    end
    evt_q.delete();

    // Move the pointer to 3 with a tap on button 3, then all four again
    btn_lvl[3] = 1'b0;
    step(2);                               // edge 126
    btn_lvl[3] = 1'b1;
    step(4);                               // edge 130
    evt_q.delete();
    btn_lvl = 4'h0;
    step(6);                               // edge 136
    btn_lvl = 4'hF;
    step(6);                               // edge 142
    check("rr_b_count", evt_q.size(), 8);
    for (int k = 0; k < 4; k++) begin
      check_evt(k,     k, P, 132 + k);
      check_evt(k + 4, k, R, 138 + k);
    end
    evt_q.delete();
    step(2);                               // edge 144

    // Back-pressure: fill the FIFO, park two RELEASEs, then drop two PRESSes
    evt_ready = 1'b0;
    btn_lvl   = 4'b1000;
    step(4);                               // edge 148
    btn_lvl   = 4'hF;
    step(3);                               // edge 151
    check("bp_no_ovf_yet", overflow,  0);
    check("bp_head_valid", evt_valid, 1);
    check("bp_head_id",    evt_id,    0);
    check("bp_head_type",  evt_type,  P);
    btn_lvl = 4'b1001;
    step(1);                               // edge 152
    check("bp_ovf_set", overflow, 1);
    step(1);                               // edge 153
    check("bp_head_stable", evt_id, 0);
    check("bp_ovf_sticky",  overflow, 1);
    ovf_clr = 1'b1;
    step(1);                               // edge 154
    check("bp_ovf_cleared", overflow, 0);
    ovf_clr = 1'b0;
    step(2);                               // edge 156
    check("bp_ovf_stays_clear", overflow, 0);
    check("bp_nothing_popped",  evt_q.size(), 0);
    evt_ready = 1'b1;
    step(6);                               // edge 162
    check("drain_count", evt_q.size(), 6);
    for (int k = 0; k < 6; k++) check_evt(k, drain_ids[k], drain_typ[k], 156 + k);
    btn_lvl = 4'hF;
    step(6);                               // edge 168
    check_evt(6, 1, R, 164);
    check_evt(7, 2, R, 165);

    // Reset while button 3 is held with two events queued
    evt_ready = 1'b0;
    btn_lvl   = 4'b0110;
    step(3);                               // edge 171
    check("mid_head_valid", evt_valid, 1);
    check("mid_head_id",    evt_id,    3);
    check("mid_head_type",  evt_type,  P);
    reset = 1'b1;
    step(1);                               // edge 172
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_id",    evt_id,    0);
    check("mid_rst_type",  evt_type,  0);
    check("mid_rst_ovf",   overflow,  0);
    btn_lvl[0] = 1'b1;
    evt_ready  = 1'b1;
    step(1);                               // edge 173
    reset = 1'b0;
    step(1);                               // edge 174
    check("post_rst_lat1", evt_valid, 0);
    step(1);                               // edge 175
    check("post_rst_valid", evt_valid, 1);
    check("post_rst_id",    evt_id,    3);
    check("post_rst_type",  evt_type,  P);
    step(1);                               // edge 176
    check("post_rst_single", evt_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
